// File: rtl/seq_hex_bin_encoder.sv
// seq_hex_bin_encoder
// Sequential priority encoder: takes an N-bit request vector and emits the
// binary index of every set bit, one per beat, lowest-first (MSB_FIRST=0) or
// highest-first (MSB_FIRST=1). Valid/ready handshakes on both sides, with
// back-to-back vector acceptance on the final beat of the current vector.
// Optional feature macro: ENC_COUNT_EN adds the out_count port, which reports
// the number of set bits still to be emitted, including the current beat.
module seq_hex_bin_encoder #(
  parameter int N         = 16,
  parameter bit MSB_FIRST = 1'b0,
  localparam int W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
`ifdef ENC_COUNT_EN
  output logic         out_zero,
  output logic [W:0]   out_count
`else
  output logic         out_zero
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic [W-1:0]   out_idx_q, out_idx_d;
  logic           out_last_q, out_last_d;
  logic           out_zero_q, out_zero_d;
  logic           accept;
`ifdef ENC_COUNT_EN
  logic [W:0]     out_count_q, out_count_d;
`endif

  // Priority pick: walking towards the preferred end, so the last hit wins.
  function automatic logic [W-1:0] prio_enc(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) r = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (v[i]) r = W'(i);
      end
    end
    return r;
  endfunction

`ifdef ENC_COUNT_EN
  function automatic logic [W:0] popcount(input logic [N-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + (W+1)'(v[i]);
    end
    return c;
  endfunction
`endif

  // State and beat registers; reset abandons any vector in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_zero_q  <= 1'b0;
`ifdef ENC_COUNT_EN
      out_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_zero_q  <= out_zero_d;
`ifdef ENC_COUNT_EN
      out_count_q <= out_count_d;
`endif
    end
  end

  // Next state: a new vector keeps us in SCAN, the last beat without one ends it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = SCAN;
      SCAN: if (out_ready && out_last_q && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; accepting is allowed while idle or on the final transfer.
  always_comb begin
    out_valid = (state_q == SCAN);
    in_ready  = (state_q == IDLE) || (out_ready && out_last_q);
    accept    = in_valid && in_ready;
  end

  // Shadow update and beat fields, precomputed from the next shadow value.
  always_comb begin
    shadow_d = shadow_q;
    if (accept) begin
      shadow_d = in_vec;
    end else if (state_q == SCAN && out_ready) begin
      if (out_last_q) shadow_d = '0;
      else            shadow_d = shadow_q & ~({{(N-1){1'b0}}, 1'b1} << out_idx_q);
    end

    out_idx_d   = '0;
    out_last_d  = 1'b0;
    out_zero_d  = 1'b0;
`ifdef ENC_COUNT_EN
    out_count_d = '0;
`endif
    if (state_d == SCAN) begin
      out_idx_d   = prio_enc(shadow_d);
      out_last_d  = ((shadow_d & (shadow_d - 1'b1)) == '0);
      out_zero_d  = (shadow_d == '0);
`ifdef ENC_COUNT_EN
      out_count_d = popcount(shadow_d);
`endif
    end
  end

  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_zero  = out_zero_q;
`ifdef ENC_COUNT_EN
  assign out_count = out_count_q;
`endif

endmodule

// File: tb/tb_seq_hex_bin_encoder.sv
// tb_seq_hex_bin_encoder
// Drives one LSB-first and one MSB-first encoder with identical inputs and
// compares every cycle against a queue of expected beats built from the set
// bits of each accepted vector. Define ENC_COUNT_EN to also check out_count.
module tb_seq_hex_bin_encoder;

  localparam int N = 16;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] idx_lsb;
    logic [W-1:0] idx_msb;
    logic         last;
    logic         zero;
    logic [W:0]   cnt;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_vec = '0;
  logic         out_ready = 1'b0;
  logic         in_ready_l, in_ready_m;
  logic         out_valid_l, out_valid_m;
  logic [W-1:0] out_idx_l, out_idx_m;
  logic         out_last_l, out_last_m;
  logic         out_zero_l, out_zero_m;
`ifdef ENC_COUNT_EN
  logic [W:0]   out_count_l, out_count_m;
`endif

  int    tests_run = 0;
  int    tests_failed = 0;
  beat_t exp_q[$];
  bit    accepted;
  bit    rand_ready = 1'b0;

  always #5 clk = ~clk;

  seq_hex_bin_encoder #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_idx(out_idx_l), .out_last(out_last_l),
`ifdef ENC_COUNT_EN
    .out_zero(out_zero_l), .out_count(out_count_l)
`else
    .out_zero(out_zero_l)
`endif
  );

  seq_hex_bin_encoder #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_idx(out_idx_m), .out_last(out_last_m),
`ifdef ENC_COUNT_EN
    .out_zero(out_zero_m), .out_count(out_count_m)
`else
    .out_zero(out_zero_m)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beats of one vector: its set bits in ascending and descending order.
  task automatic push_vector(input logic [N-1:0] v);
    int    bits[$];
    int    k;
    beat_t b;
    for (int i = 0; i < N; i++) if (v[i]) bits.push_back(i);
    k = bits.size();
    if (k == 0) begin
      b.idx_lsb = '0; b.idx_msb = '0; b.last = 1'b1; b.zero = 1'b1; b.cnt = '0;
      exp_q.push_back(b);
    end else begin
      for (int j = 0; j < k; j++) begin
        b.idx_lsb = W'(bits[j]);
        b.idx_msb = W'(bits[k-1-j]);
        b.last    = (j == k - 1);
        b.zero    = 1'b0;
        b.cnt     = (W+1)'(k - j);
        exp_q.push_back(b);
      end
    end
  endtask

  // Called mid-cycle: compares both DUTs with the model, then retires/accepts.
  task automatic checkOutput();
    logic exp_ready;
    if (rst) begin
      exp_q.delete();
      return;
    end
    exp_ready = (exp_q.size() == 0) || (out_ready && exp_q[0].last);
    chk("out_valid_lsb", out_valid_l, exp_q.size() != 0);
    chk("out_valid_msb", out_valid_m, exp_q.size() != 0);
    chk("in_ready_lsb", in_ready_l, exp_ready);
    chk("in_ready_msb", in_ready_m, exp_ready);
    if (exp_q.size() != 0) begin
      chk("idx_lsb", out_idx_l, exp_q[0].idx_lsb);
      chk("idx_msb", out_idx_m, exp_q[0].idx_msb);
      chk("last_lsb", out_last_l, exp_q[0].last);
      chk("last_msb", out_last_m, exp_q[0].last);
      chk("zero_lsb", out_zero_l, exp_q[0].zero);
      chk("zero_msb", out_zero_m, exp_q[0].zero);
`ifdef ENC_COUNT_EN
      chk("count_lsb", out_count_l, exp_q[0].cnt);
      chk("count_msb", out_count_m, exp_q[0].cnt);
`endif
      if (out_ready) void'(exp_q.pop_front());
    end
    if (in_valid && exp_ready) begin
      push_vector(in_vec);
      accepted = 1'b1;
    end
  endtask

  // One clock: check at the falling edge, return just after the rising edge.
  task automatic tick();
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v);
    int n;
    in_valid = 1'b1;
    in_vec   = v;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 100) begin
      tick();
      n++;
    end
    chk("accept_timeout", accepted, 1'b1);
    in_valid = 1'b0;
    in_vec   = N'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", exp_q.size() == 0, 1'b1);
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, {out_valid_l, out_valid_m}, 2'b00);
    chk({tag, "_ready"}, {in_ready_l, in_ready_m}, 2'b11);
    chk({tag, "_idx"}, {out_idx_l, out_idx_m}, 8'h00);
    chk({tag, "_flags"}, {out_last_l, out_zero_l, out_last_m, out_zero_m}, 4'b0000);
`ifdef ENC_COUNT_EN
    chk({tag, "_count"}, {out_count_l, out_count_m}, 10'd0);
`endif
  endtask

  initial begin
    logic [N-1:0] v;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_values("reset");

    // Four spread bits with a consumer that never stalls.
    out_ready = 1'b1;
    applyStimulus(16'h8421);
    chk("t1_first_idx", out_idx_l, 4'd0);
    drain();

    // All-zero vector gives one zero beat and then idle.
    applyStimulus(16'h0000);
    chk("t2_zero", {out_valid_l, out_zero_l, out_last_l}, 3'b111);
    drain();
    chk("t2_idle_ready", in_ready_l, 1'b1);

    // Stall on the first beat: outputs must hold.
    out_ready = 1'b0;
    applyStimulus(16'h0006);
    tick();
    chk("t3_held_msb", out_idx_m, 4'd2);
    out_ready = 1'b1;
    drain();

    // Back-to-back vectors with in_valid held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 16'h0003;
    tick();
    in_vec    = 16'h0100;
    tick();
    tick();
    in_valid  = 1'b0;
    in_vec    = 16'hFFFF;
    chk("t4_third_idx", out_idx_l, 4'd8);
    drain();

    // Reset while the first beat (idx 5) is showing.
    applyStimulus(16'hFFE0);
    chk("t5_idx5", out_idx_l, 4'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("midscan_reset");
    applyStimulus(16'h0001);
    drain();

    // Random vectors, random stalls, random gaps.
    rand_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = N'($urandom) & N'($urandom) & N'($urandom);
        default: v = N'($urandom);
      endcase
      applyStimulus(v);
      if ($urandom_range(0, 2) == 0) tick();
    end
    drain();
    rand_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
